// File: rtl/makina_pkg.sv
// Shared definitions for the instruction sequencer: address width, sequencer states, fault codes.
// No logic; no latency; no backpressure.
// Imported by pc_sequencer and return_stack.
package makina_pkg;
    localparam int ADDR_W = 16;
    localparam int LVL_W  = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;
endpackage

// File: rtl/return_stack.sv
// Return-address LIFO: push writes at the current level, top is the most recent entry.
// Push/pop take effect on the next edge; top is combinational from the stored entries.
// No backpressure: push when full and pop when empty are ignored; the caller flags them.
module return_stack
    import makina_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_dat,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [LVL_W-1:0]  level_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx = IDX_W'(level_q);
    assign rd_idx = IDX_W'(level_q - LVL_W'(1));
    assign full   = (level_q == LVL_W'(STACK_DEPTH));
    assign empty  = (level_q == '0);
    assign top    = empty ? '0 : mem[rd_idx];
    assign level  = level_q;

    // Entries are never reset; only the occupancy count is.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + LVL_W'(1);
        end else if (pop && !empty) begin
            level_q <= level_q - LVL_W'(1);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with call/return stack, halt and sticky fault states.
// pc updates one edge after the selected action; fetch_valid is combinational.
// stall freezes pc and stack and drops fetch_valid for that cycle.
module pc_sequencer
    import makina_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          STACK_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              pc_write_enabled,
    input  logic [ADDR_W-1:0] dest_address,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [LVL_W-1:0]  stack_level
);
    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [1:0]        fc_q, fc_nxt;
    logic              push, pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full, stk_empty;

    return_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_dat (pc_q + ADDR_W'(1)),
        .top      (stk_top),
        .full     (stk_full),
        .empty    (stk_empty),
        .level    (stack_level)
    );

    // One action per RUN cycle: halt > stall > ret > call > branch > increment.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        fc_nxt    = fc_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (state_q == RUN) begin
            if (halt) begin
                state_nxt = HALTED;
            end else if (stall) begin
                pc_nxt = pc_q;
            end else if (ret) begin
                if (stk_empty) begin
                    state_nxt = FAULT;
                    fc_nxt    = FC_UNDERFLOW;
                end else begin
                    pop    = 1'b1;
                    pc_nxt = stk_top;
                end
            end else if (call) begin
                if (stk_full) begin
                    state_nxt = FAULT;
                    fc_nxt    = FC_OVERFLOW;
                end else begin
                    push   = 1'b1;
                    pc_nxt = dest_address;
                end
            end else if (pc_write_enabled) begin
                pc_nxt = dest_address;
            end else begin
                pc_nxt = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            fc_q    <= FC_NONE;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            fc_q    <= fc_nxt;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN) && !stall && !rst;
    assign halted      = (state_q == HALTED);
    assign fault       = (state_q == FAULT);
    assign fault_code  = fc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pc_sequencer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        pc_write_enabled = 1'b0;
    logic [15:0] dest_address = 16'h0000;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [4:0]  stack_level;

    pc_sequencer #(
        .RESET_VECTOR(16'h0000),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .pc_write_enabled (pc_write_enabled),
        .dest_address     (dest_address),
        .call             (call),
        .ret              (ret),
        .halt             (halt),
        .pc               (pc),
        .fetch_valid      (fetch_valid),
        .halted           (halted),
        .fault            (fault),
        .fault_code       (fault_code),
        .stack_level      (stack_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = running, 1 = halted, 2 = faulted.
    int          m_mode = 0;
    logic [15:0] m_pc = 16'h0000;
    logic [1:0]  m_fc = 2'b00;
    logic [15:0] m_stk[$];
    logic        m_fv = 1'b0;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        if (rst) begin
            m_pc   = 16'h0000;
            m_mode = 0;
            m_fc   = 2'b00;
            m_stk.delete();
        end else if (m_mode == 0) begin
            if (halt) begin
                m_mode = 1;
            end else if (stall) begin
                m_mode = 0;
            end else if (ret) begin
                if (m_stk.size() == 0) begin
                    m_mode = 2;
                    m_fc   = 2'b10;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (call) begin
                if (m_stk.size() == DEPTH) begin
                    m_mode = 2;
                    m_fc   = 2'b01;
                end else begin
                    m_stk.push_back(m_pc + 16'd1);
                    m_pc = dest_address;
                end
            end else if (pc_write_enabled) begin
                m_pc = dest_address;
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
            check("halted", 32'(halted), 32'(m_mode == 1));
            check("fault", 32'(fault), 32'(m_mode == 2));
            check("fault_code", 32'(fault_code), 32'(m_fc));
            check("stack_level", 32'(stack_level), 32'(m_stk.size()));
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the edge with inputs still held.
    task automatic cyc(input logic r, input logic s, input logic w, input logic [15:0] d,
                       input logic c, input logic rt, input logic h);
        rst = r; stall = s; pc_write_enabled = w; dest_address = d;
        call = c; ret = rt; halt = h;
        m_fv = !r && (m_mode == 0) && !s;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
    endtask

    initial begin
        do_reset();
        do_reset();
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_level", 32'(stack_level), 32'd0);
        idle(); idle(); idle();
        check("idle3_pc", 32'(pc), 32'h0003);
        check("idle3_model_pc", 32'(m_pc), 32'h0003);
        check("idle3_fv", 32'(fetch_valid), 32'd1);

        // Branch, with a stalled branch attempt first.
        cyc(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0);
        check("stall_pc", 32'(pc), 32'h0010);
        check("stall_fv", 32'(fetch_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0);
        check("branch_pc", 32'(pc), 32'h0080);

        // Call at 0005 then return; branch enable alongside call is ignored.
        cyc(1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
        check("call_pc", 32'(pc), 32'h0100);
        check("call_level", 32'(stack_level), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 16'h0777, 1'b0, 1'b1, 1'b0);
        check("ret_pc", 32'(pc), 32'h0006);
        check("ret_level", 32'(stack_level), 32'd0);

        // Nested calls until overflow, then inputs ignored in FAULT.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 16'(16'h0200 + i * 16'h0100), 1'b1, 1'b0, 1'b0);
        check("nest_level", 32'(stack_level), 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 16'h0600, 1'b1, 1'b0, 1'b0);
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_code", 32'(fault_code), 32'b01);
        check("ovf_pc", 32'(pc), 32'h0500);
        cyc(1'b0, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("fault_hold_pc", 32'(pc), 32'h0500);
        check("fault_fv", 32'(fetch_valid), 32'd0);
        do_reset();
        check("fault_rst_pc", 32'(pc), 32'h0000);
        check("fault_rst_fault", 32'(fault), 32'd0);

        // Return with an empty stack.
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("unf_code", 32'(fault_code), 32'b10);
        check("unf_pc", 32'(pc), 32'h0000);
        do_reset();

        // Wrap, then call and ret together.
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        idle();
        check("wrap_pc", 32'(pc), 32'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0900, 1'b1, 1'b1, 1'b0);
        check("callret_pc", 32'(pc), 32'h0001);
        check("callret_level", 32'(stack_level), 32'd0);

        // Halt holds against branch/call inputs until reset.
        cyc(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 16'h0123, i[0], 1'b0, 1'b0);
        check("halt_pc", 32'(pc), 32'h0020);
        check("halt_flag", 32'(halted), 32'd1);
        do_reset();
        idle();
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_pc", 32'(pc), 32'h0001);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
